// File: rtl/idex_reg_hazard.sv
// ID/EX pipeline register with built-in load-use hazard detection.
// A load-use stalls IF/ID for one cycle and injects a bubble; flush and hold take priority.
module idex_reg_hazard #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   ID_pc_i,
  input  logic [XLEN-1:0]   ID_rs1_data_i,
  input  logic [XLEN-1:0]   ID_rs2_data_i,
  input  logic [XLEN-1:0]   ID_imm_i,
  input  logic [4:0]        ID_rs1_i,
  input  logic [4:0]        ID_rs2_i,
  input  logic [4:0]        ID_rd_i,
  input  logic              ID_rs1_used_i,
  input  logic              ID_rs2_used_i,
  input  logic              ID_valid_i,
  input  logic              ID_rd_wren_i,
  input  logic              ID_mem_rden_i,
  input  logic              ID_mem_wren_i,
  input  logic [CTRL_W-1:0] ID_ctrl_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [XLEN-1:0]   IDEX_pc_o,
  output logic [XLEN-1:0]   IDEX_rs1_data_o,
  output logic [XLEN-1:0]   IDEX_rs2_data_o,
  output logic [XLEN-1:0]   IDEX_imm_o,
  output logic [4:0]        IDEX_rs1_o,
  output logic [4:0]        IDEX_rs2_o,
  output logic [4:0]        IDEX_rd_o,
  output logic              IDEX_valid_o,
  output logic              IDEX_rd_wren_o,
  output logic              IDEX_mem_rden_o,
  output logic              IDEX_mem_wren_o,
  output logic [CTRL_W-1:0] IDEX_ctrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              valid;
    logic              rd_wren;
    logic              mem_rden;
    logic              mem_wren;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  idex_t            idex_q, idex_d, id_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs1_hit_s, rs2_hit_s, lu_s;

  assign id_s = {ID_pc_i, ID_rs1_data_i, ID_rs2_data_i, ID_imm_i,
                 ID_rs1_i, ID_rs2_i, ID_rd_i,
                 ID_valid_i, ID_rd_wren_i, ID_mem_rden_i, ID_mem_wren_i,
                 ID_ctrl_i};

  // A load writing x0 never creates a dependency, so it is excluded here.
  assign rs1_hit_s = ID_rs1_used_i && (ID_rs1_i == idex_q.rd);
  assign rs2_hit_s = ID_rs2_used_i && (ID_rs2_i == idex_q.rd);
  assign lu_s      = idex_q.valid && idex_q.mem_rden && (idex_q.rd != 5'd0) &&
                     ID_valid_i && (rs1_hit_s || rs2_hit_s);
  assign stall_o   = lu_s && !flush_i && !hold_i;

  // Next-state selection: flush, then hold, then load-use bubble, then capture.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      idex_d = '0;
    end else if (hold_i) begin
      idex_d = idex_q;
    end else if (lu_s) begin
      idex_d = '0;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (ID_valid_i) begin
      idex_d = id_s;
    end else begin
      idex_d = '0;
    end
  end

  // Pipeline register and bubble counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign IDEX_pc_o       = idex_q.pc;
  assign IDEX_rs1_data_o = idex_q.rs1_data;
  assign IDEX_rs2_data_o = idex_q.rs2_data;
  assign IDEX_imm_o      = idex_q.imm;
  assign IDEX_rs1_o      = idex_q.rs1;
  assign IDEX_rs2_o      = idex_q.rs2;
  assign IDEX_rd_o       = idex_q.rd;
  assign IDEX_valid_o    = idex_q.valid;
  assign IDEX_rd_wren_o  = idex_q.rd_wren;
  assign IDEX_mem_rden_o = idex_q.mem_rden;
  assign IDEX_mem_wren_o = idex_q.mem_wren;
  assign IDEX_ctrl_o     = idex_q.ctrl;
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_idex_reg_hazard.sv
// Randomized bench for idex_reg_hazard: instruction-level reference model plus directed scenarios.
// A second instance with a 4-bit counter exercises saturation.
module tb_idex_reg_hazard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ID_pc, ID_r1d, ID_r2d, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic        ID_u1, ID_u2, ID_valid, ID_wr, ID_mrd, ID_mwr;
  logic [15:0] ID_ctrl;
  logic        flush, hold;

  logic [31:0] o_pc, o_r1d, o_r2d, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_valid, o_wr, o_mrd, o_mwr, o_stall;
  logic [15:0] o_ctrl;
  logic [31:0] o_cnt;

  logic [31:0] s_pc, s_r1d, s_r2d, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_valid, s_wr, s_mrd, s_mwr, s_stall;
  logic [15:0] s_ctrl;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  idex_reg_hazard u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ID_pc_i(ID_pc), .ID_rs1_data_i(ID_r1d), .ID_rs2_data_i(ID_r2d), .ID_imm_i(ID_imm),
    .ID_rs1_i(ID_rs1), .ID_rs2_i(ID_rs2), .ID_rd_i(ID_rd),
    .ID_rs1_used_i(ID_u1), .ID_rs2_used_i(ID_u2), .ID_valid_i(ID_valid),
    .ID_rd_wren_i(ID_wr), .ID_mem_rden_i(ID_mrd), .ID_mem_wren_i(ID_mwr),
    .ID_ctrl_i(ID_ctrl), .flush_i(flush), .hold_i(hold),
    .IDEX_pc_o(o_pc), .IDEX_rs1_data_o(o_r1d), .IDEX_rs2_data_o(o_r2d), .IDEX_imm_o(o_imm),
    .IDEX_rs1_o(o_rs1), .IDEX_rs2_o(o_rs2), .IDEX_rd_o(o_rd),
    .IDEX_valid_o(o_valid), .IDEX_rd_wren_o(o_wr), .IDEX_mem_rden_o(o_mrd),
    .IDEX_mem_wren_o(o_mwr), .IDEX_ctrl_o(o_ctrl), .stall_o(o_stall), .bubble_cnt_o(o_cnt)
  );

  idex_reg_hazard #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .ID_pc_i(ID_pc), .ID_rs1_data_i(ID_r1d), .ID_rs2_data_i(ID_r2d), .ID_imm_i(ID_imm),
    .ID_rs1_i(ID_rs1), .ID_rs2_i(ID_rs2), .ID_rd_i(ID_rd),
    .ID_rs1_used_i(ID_u1), .ID_rs2_used_i(ID_u2), .ID_valid_i(ID_valid),
    .ID_rd_wren_i(ID_wr), .ID_mem_rden_i(ID_mrd), .ID_mem_wren_i(ID_mwr),
    .ID_ctrl_i(ID_ctrl), .flush_i(flush), .hold_i(hold),
    .IDEX_pc_o(s_pc), .IDEX_rs1_data_o(s_r1d), .IDEX_rs2_data_o(s_r2d), .IDEX_imm_o(s_imm),
    .IDEX_rs1_o(s_rs1), .IDEX_rs2_o(s_rs2), .IDEX_rd_o(s_rd),
    .IDEX_valid_o(s_valid), .IDEX_rd_wren_o(s_wr), .IDEX_mem_rden_o(s_mrd),
    .IDEX_mem_wren_o(s_mwr), .IDEX_ctrl_o(s_ctrl), .stall_o(s_stall), .bubble_cnt_o(s_cnt)
  );

  // Reference model: the instruction currently in EX, or a bubble.
  typedef struct {
    bit          v, wr, mrd, mwr;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] ctrl;
  } instr_t;

  instr_t      ex;
  longint      cnt32, cnt4;

  function automatic instr_t bubble();
    instr_t b;
    b.v = 1'b0; b.wr = 1'b0; b.mrd = 1'b0; b.mwr = 1'b0;
    b.pc = 32'd0; b.r1d = 32'd0; b.r2d = 32'd0; b.imm = 32'd0;
    b.rs1 = 5'd0; b.rs2 = 5'd0; b.rd = 5'd0; b.ctrl = 16'd0;
    return b;
  endfunction

  // ID depends on a load still in EX, whose data is not available for forwarding yet.
  function automatic bit load_use();
    bit ex_is_load = ex.v && ex.mrd && (ex.rd != 5'd0);
    bit reads_it   = (ID_u1 && ID_rs1 == ex.rd) || (ID_u2 && ID_rs2 == ex.rd);
    return ex_is_load && ID_valid && reads_it;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex = bubble(); cnt32 = 0; cnt4 = 0;
    end else if (flush) begin
      ex = bubble();
    end else if (hold) begin
      ex = ex;
    end else if (load_use()) begin
      ex = bubble();
      cnt32 = (cnt32 < 64'hFFFF_FFFF) ? cnt32 + 1 : cnt32;
      cnt4  = (cnt4 < 15) ? cnt4 + 1 : cnt4;
    end else if (ID_valid) begin
      ex.v = 1'b1; ex.wr = ID_wr; ex.mrd = ID_mrd; ex.mwr = ID_mwr;
      ex.pc = ID_pc; ex.r1d = ID_r1d; ex.r2d = ID_r2d; ex.imm = ID_imm;
      ex.rs1 = ID_rs1; ex.rs2 = ID_rs2; ex.rd = ID_rd; ex.ctrl = ID_ctrl;
    end else begin
      ex = bubble();
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("pc", 64'(o_pc), 64'(ex.pc));
      chk("rs1_data", 64'(o_r1d), 64'(ex.r1d));
      chk("rs2_data", 64'(o_r2d), 64'(ex.r2d));
      chk("imm", 64'(o_imm), 64'(ex.imm));
      chk("rs1", 64'(o_rs1), 64'(ex.rs1));
      chk("rs2", 64'(o_rs2), 64'(ex.rs2));
      chk("rd", 64'(o_rd), 64'(ex.rd));
      chk("valid", 64'(o_valid), 64'(ex.v));
      chk("rd_wren", 64'(o_wr), 64'(ex.wr));
      chk("mem_rden", 64'(o_mrd), 64'(ex.mrd));
      chk("mem_wren", 64'(o_mwr), 64'(ex.mwr));
      chk("ctrl", 64'(o_ctrl), 64'(ex.ctrl));
      chk("stall", 64'(o_stall), 64'(load_use() && !flush && !hold));
      chk("bubble_cnt", 64'(o_cnt), 64'(cnt32));
      chk("sat_stall", 64'(s_stall), 64'(load_use() && !flush && !hold));
      chk("sat_cnt", 64'(s_cnt), 64'(cnt4));
    end
  end

  task automatic drive_rand();
    ID_pc = $urandom; ID_r1d = $urandom; ID_r2d = $urandom; ID_imm = $urandom;
    ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
    ID_rd = 5'($urandom_range(0, 3));
    ID_u1 = 1'($urandom_range(0, 1)); ID_u2 = 1'($urandom_range(0, 1));
    ID_valid = ($urandom_range(0, 9) != 0);
    ID_wr = 1'($urandom_range(0, 1));
    ID_mrd = ($urandom_range(0, 2) == 0);
    ID_mwr = 1'($urandom_range(0, 1));
    ID_ctrl = 16'($urandom);
    flush = ($urandom_range(0, 15) == 0);
    hold = ($urandom_range(0, 9) == 0);
  endtask

  task automatic drive_ins(input logic [31:0] pc, input logic [4:0] rs1, input bit u1,
                           input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                           input bit mrd, input bit mwr);
    ID_pc = pc; ID_r1d = $urandom; ID_r2d = $urandom; ID_imm = $urandom;
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd; ID_u1 = u1; ID_u2 = u2;
    ID_valid = 1'b1; ID_wr = !mwr; ID_mrd = mrd; ID_mwr = mwr;
    ID_ctrl = 16'($urandom); flush = 1'b0; hold = 1'b0;
  endtask

  task automatic drive_idle();
    drive_ins(32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ID_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_rand();
    repeat (3) begin
      @(negedge clk); drive_rand();
    end
    chk_en = 1'b1;
    @(negedge clk); drive_rand(); #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_cnt", 64'(o_cnt), 64'd0);

    // First capture after reset release.
    @(negedge clk); rst_n = 1'b1; drive_ins(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk); drive_idle(); #3;
    chk("first_pc", 64'(o_pc), 64'h100);
    chk("first_rd", 64'(o_rd), 64'd5);
    chk("first_valid", 64'(o_valid), 64'd1);

    // lw x7 then add x3,x1,x7.
    @(negedge clk); drive_ins(32'h104, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    @(negedge clk); drive_ins(32'h108, 5'd1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0); #3;
    chk("lu_stall", 64'(o_stall), 64'd1);
    @(negedge clk); #3;
    chk("lu_bubble_valid", 64'(o_valid), 64'd0);
    chk("lu_cnt", 64'(o_cnt), 64'd1);
    chk("lu_stall_once", 64'(o_stall), 64'd0);
    @(negedge clk); drive_idle(); #3;
    chk("lu_add_rs2", 64'(o_rs2), 64'd7);
    chk("lu_add_pc", 64'(o_pc), 64'h108);
    chk("lu_add_stall", 64'(o_stall), 64'd0);

    // lw x0 then use of x0.
    @(negedge clk); drive_ins(32'h200, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk); drive_ins(32'h204, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0); #3;
    chk("x0_stall", 64'(o_stall), 64'd0);
    // sw whose rd field is 7, then a reader of x7.
    @(negedge clk); drive_ins(32'h208, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b1); #3;
    chk("x0_captured_pc", 64'(o_pc), 64'h204);
    @(negedge clk); drive_ins(32'h20c, 5'd7, 1'b1, 5'd7, 1'b1, 5'd4, 1'b0, 1'b0); #3;
    chk("sw_stall", 64'(o_stall), 64'd0);
    // lw x7 with ID rs1=7 but unused.
    @(negedge clk); drive_ins(32'h210, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); #3;
    chk("sw_captured_pc", 64'(o_pc), 64'h20c);
    @(negedge clk); drive_ins(32'h214, 5'd7, 1'b0, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0); #3;
    chk("unused_stall", 64'(o_stall), 64'd0);
    @(negedge clk); drive_idle(); #3;
    chk("unused_captured_pc", 64'(o_pc), 64'h214);
    chk("no_stall_cnt", 64'(o_cnt), 64'd1);

    // Flush together with a load-use and hold.
    @(negedge clk); drive_ins(32'h300, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    @(negedge clk); drive_ins(32'h304, 5'd7, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0);
    flush = 1'b1; hold = 1'b1; #3;
    chk("flush_stall", 64'(o_stall), 64'd0);
    @(negedge clk); drive_idle(); #3;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_pc", 64'(o_pc), 64'd0);
    chk("flush_cnt", 64'(o_cnt), 64'd1);

    // Hold three cycles with a pending load-use, then release.
    @(negedge clk); drive_ins(32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_ins(32'h500 + 32'(i * 4), 5'd7, 1'b1, 5'(i), 1'b1, 5'd9, 1'b0, 1'b0);
      hold = 1'b1; #3;
      chk("hold_pc", 64'(o_pc), 64'h400);
      chk("hold_stall", 64'(o_stall), 64'd0);
    end
    @(negedge clk); hold = 1'b0; #3;
    chk("hold_pc_kept", 64'(o_pc), 64'h400);
    chk("release_stall", 64'(o_stall), 64'd1);
    @(negedge clk); drive_idle(); #3;
    chk("release_bubble", 64'(o_valid), 64'd0);
    chk("release_cnt", 64'(o_cnt), 64'd2);

    // Reset asserted during a stall.
    @(negedge clk); drive_ins(32'h600, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    @(negedge clk); drive_ins(32'h604, 5'd6, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0); #3;
    chk("mid_stall", 64'(o_stall), 64'd1);
    #1 rst_n = 1'b0; #1;
    chk("mid_rst_stall", 64'(o_stall), 64'd0);
    chk("mid_rst_cnt", 64'(o_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1; drive_idle();

    // Seventeen load-use events against both counter widths.
    for (int e = 0; e < 17; e++) begin
      @(negedge clk); drive_ins(32'h700 + 32'(e), 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      @(negedge clk); drive_ins(32'h800 + 32'(e), 5'd0, 1'b0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0);
      @(negedge clk); drive_idle(); #3;
      if (e == 14) chk("sat_cnt_15", 64'(s_cnt), 64'd15);
    end
    chk("sat_cnt_hold", 64'(s_cnt), 64'd15);
    chk("wide_cnt_17", 64'(o_cnt), 64'd17);

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive_rand();
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk); rst_n = 1'b1; drive_idle();
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
